ship_placement_ctrl: RTL and testbench
======================================

// Module: ship_placement_ctrl
// PURPOSE
//  Upstream producer of the 5x5 board consumed by the ship block drawer. Turns
//  debounced player buttons into a moving cursor. Validates each requested ship
//  placement (bounds + overlap), then writes ship cells into the board. The
//  drawer reads matrix[y][x] and paints every cell equal to CELL_SHIP.
// PARAMETERS
//  BOARD_N    5  board side, in cells; cursor range 0..BOARD_N-1
//  MAX_SHIPS  5  upper clamp for num_ships; ship i (0-based) has length i+1
//  CELL_SHIP  6  cell code written for ship cells (taken from battleship_pkg)
// PORTS
//  clk         in   1      system clock, single clock domain
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      level; rising edge clears the board and starts a round
//  btn_up      in   1      level; a rising edge moves the cursor to y-1
//  btn_down    in   1      level; a rising edge moves the cursor to y+1
//  btn_left    in   1      level; a rising edge moves the cursor to x-1
//  btn_right   in   1      level; a rising edge moves the cursor to x+1
//  btn_rotate  in   1      level; a rising edge toggles orient
//  btn_place   in   1      level; a rising edge requests placement at the cursor
//  num_ships   in   3      ships per round; latched on start
//  matrix      out  int[4:0][4:0]  board, indexed [y][x]; 0 = water, 6 = ship
//  cursor_x    out  3      cursor column
//  cursor_y    out  3      cursor row
//  orient      out  1      0 = horizontal (+x), 1 = vertical (+y)
//  ship_idx    out  3      index of the ship currently being placed
//  busy        out  1      1 while in CHECK or WRITE
//  place_err   out  1      1-cycle pulse when a placement is rejected
//  done        out  1      held at 1 once all ships are placed
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): matrix all 0, cursor (0,0), orient 0,
//    ship_idx 0, busy/place_err/done 0, state IDLE, edge-detect registers 0.
//  - Edge detect: pulse = btn & ~btn_q. The action takes effect at the same
//    clk edge that samples the first high level.
//  - Button pulses are dropped in IDLE, CHECK, WRITE and DONE.
//  - start pulse, any state: every matrix cell cleared to 0 on that edge; ship_idx 0;
//    cursor (0,0); num_ships latched; go to SELECT. start overrides all else.
//  - num_ships clamp: 0 -> 1; >MAX_SHIPS -> MAX_SHIPS.
//  - SELECT, cursor moves: saturate at 0 and BOARD_N-1, no wrap.
//  - SELECT, opposing buttons (up+down, or left+right) in one cycle: no change
//    on that axis. Moves on both axes in one cycle both apply.
//  - SELECT priority: place > rotate > moves. A place pulse ignores same-cycle
//    rotate/move pulses, sets len=ship_idx+1 and k=0, and goes to CHECK.
//  - CHECK, one cell per cycle: cell = cursor + k along orient (4-bit sum).
//    If a coordinate > BOARD_N-1 or matrix[cell]==CELL_SHIP: place_err=1 for
//    one cycle, go back to SELECT, matrix unchanged. If k==len-1 and the cell
//    is valid: k=0, go to WRITE. Otherwise k++.
//  - WRITE, one cell per cycle: matrix[cell]=CELL_SHIP. At k==len-1: ship_idx++.
//    If the new ship_idx == num_ships go to DONE, else go to SELECT.
//  - Latency from the place edge to the last cell written: 2*len cycles.
//  - DONE: done=1; busy=0; only start leaves DONE.
//  - matrix changes only at clk edges; a ship is fully written before
//    ship_idx advances.
//  - rst_n asserted mid-WRITE: board clears immediately; no partial ship remains.
// STRUCTURE
//  - battleship_pkg: BOARD_N, CELL_WATER=0, CELL_SHIP=6, MAX_SHIPS, and the
//    state enum {IDLE, SELECT, CHECK, WRITE, DONE}.
//  - Sub-module btn_edge_detect (clk, rst_n, level -> pulse), one instance per
//    button and one for start.
// TESTING
//  1 Reset -> all 25 cells 0, cursor (0,0), done 0, busy 0, place_err 0.
//  2 start with num_ships=2; place at (0,0) -> after 2 cycles matrix[0][0]=6,
//    ship_idx=1, done 0.
//  3 cursor (4,0), horizontal, place (len 2) -> k=1 gives x=5, place_err one
//    pulse, matrix unchanged, state SELECT.
//  4 cursor (0,0), vertical, place -> overlap at k=0, place_err, no writes.
//  5 move to (3,2), horizontal, place -> matrix[2][3]=matrix[2][4]=6, done=1;
//    later button pulses ignored.
//  6 left held at x=0 -> x stays 0; up+down together -> y unchanged;
//    rst_n low mid-WRITE -> board all 0 at once.

Source files
------------

// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared board constants, cell codes and placement FSM states
package battleship_pkg;

  localparam int BOARD_N    = 5;
  localparam int MAX_SHIPS  = 5;
  localparam int CELL_WATER = 0;
  localparam int CELL_SHIP  = 6;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CHECK,
    WRITE,
    DONE
  } state_t;

  // A round always has at least one ship and never more than the board supports.
  function automatic logic [2:0] clamp_ships(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > 3'(MAX_SHIPS)) return 3'(MAX_SHIPS);
    return n;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// rtl/btn_edge_detect.sv - one-cycle rising-edge pulse from a debounced level
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/ship_placement_ctrl.sv
// rtl/ship_placement_ctrl.sv - cursor control, placement validation and ship writes into the 5x5 board
module ship_placement_ctrl
  import battleship_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_place,
  input  logic [2:0] num_ships,
  output int         matrix [BOARD_N-1:0][BOARD_N-1:0],
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       orient,
  output logic [2:0] ship_idx,
  output logic       busy,
  output logic       place_err,
  output logic       done
);

  state_t     state, state_nxt;
  logic [2:0] num_q, len, k;
  logic       p_start, p_up, p_down, p_left, p_right, p_rotate, p_place;
  logic [3:0] cell_x, cell_y;
  logic [2:0] cx_i, cy_i;
  logic       cell_oob, cell_hit, check_fail, last_cell;

  btn_edge_detect u_ed_start  (.clk(clk), .rst_n(rst_n), .level(start),      .pulse(p_start));
  btn_edge_detect u_ed_up     (.clk(clk), .rst_n(rst_n), .level(btn_up),     .pulse(p_up));
  btn_edge_detect u_ed_down   (.clk(clk), .rst_n(rst_n), .level(btn_down),   .pulse(p_down));
  btn_edge_detect u_ed_left   (.clk(clk), .rst_n(rst_n), .level(btn_left),   .pulse(p_left));
  btn_edge_detect u_ed_right  (.clk(clk), .rst_n(rst_n), .level(btn_right),  .pulse(p_right));
  btn_edge_detect u_ed_rotate (.clk(clk), .rst_n(rst_n), .level(btn_rotate), .pulse(p_rotate));
  btn_edge_detect u_ed_place  (.clk(clk), .rst_n(rst_n), .level(btn_place),  .pulse(p_place));

  // 4-bit sums so a ship running past the edge is seen as out of range, not wrapped.
  assign cell_x    = {1'b0, cursor_x} + (orient ? 4'd0 : {1'b0, k});
  assign cell_y    = {1'b0, cursor_y} + (orient ? {1'b0, k} : 4'd0);
  assign cell_oob  = (cell_x > 4'(BOARD_N - 1)) || (cell_y > 4'(BOARD_N - 1));
  assign cx_i      = cell_oob ? 3'd0 : cell_x[2:0];
  assign cy_i      = cell_oob ? 3'd0 : cell_y[2:0];
  assign cell_hit  = !cell_oob && (matrix[cy_i][cx_i] == CELL_SHIP);
  assign last_cell = (k == len - 3'd1);

  always_comb begin
    state_nxt  = state;
    check_fail = 1'b0;
    case (state)
      SELECT: if (p_place) state_nxt = CHECK;
      CHECK: begin
        if (cell_oob || cell_hit) begin
          check_fail = 1'b1;
          state_nxt  = SELECT;
        end else if (last_cell) begin
          state_nxt = WRITE;
        end
      end
      WRITE: if (last_cell) state_nxt = ((ship_idx + 3'd1) == num_q) ? DONE : SELECT;
      default: state_nxt = state;
    endcase
    if (p_start) state_nxt = SELECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int y = 0; y < BOARD_N; y++)
        for (int x = 0; x < BOARD_N; x++)
          matrix[y][x] <= CELL_WATER;
      cursor_x  <= 3'd0;
      cursor_y  <= 3'd0;
      orient    <= 1'b0;
      ship_idx  <= 3'd0;
      num_q     <= 3'd1;
      len       <= 3'd1;
      k         <= 3'd0;
      place_err <= 1'b0;
    end else begin
      place_err <= 1'b0;
      if (p_start) begin
        for (int y = 0; y < BOARD_N; y++)
          for (int x = 0; x < BOARD_N; x++)
            matrix[y][x] <= CELL_WATER;
        cursor_x <= 3'd0;
        cursor_y <= 3'd0;
        ship_idx <= 3'd0;
        num_q    <= clamp_ships(num_ships);
        k        <= 3'd0;
      end else begin
        case (state)
          SELECT: begin
            if (p_place) begin
              len <= ship_idx + 3'd1;
              k   <= 3'd0;
            end else if (p_rotate) begin
              orient <= ~orient;
            end else begin
              // Opposing presses on one axis cancel; the two axes are independent.
              if (p_up && !p_down && cursor_y != 3'd0) cursor_y <= cursor_y - 3'd1;
              if (p_down && !p_up && cursor_y != 3'(BOARD_N - 1)) cursor_y <= cursor_y + 3'd1;
              if (p_left && !p_right && cursor_x != 3'd0) cursor_x <= cursor_x - 3'd1;
              if (p_right && !p_left && cursor_x != 3'(BOARD_N - 1)) cursor_x <= cursor_x + 3'd1;
            end
          end
          CHECK: begin
            if (check_fail)     place_err <= 1'b1;
            else if (last_cell) k <= 3'd0;
            else                k <= k + 3'd1;
          end
          WRITE: begin
            matrix[cy_i][cx_i] <= CELL_SHIP;
            if (last_cell) begin
              ship_idx <= ship_idx + 3'd1;
              k        <= 3'd0;
            end else begin
              k <= k + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state == CHECK) || (state == WRITE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// tb/tb_ship_placement_ctrl.sv - randomized self-checking bench with a board-level reference model
module tb_ship_placement_ctrl;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_rotate = 1'b0, btn_place = 1'b0;
  logic [2:0] num_ships = 3'd0;
  int         matrix [N-1:0][N-1:0];
  logic [2:0] cursor_x, cursor_y, ship_idx;
  logic       orient, busy, place_err, done;

  int n_checks = 0;
  int n_fail = 0;

  int mb [N][N];
  int mx, my, mo, midx, mnum;
  bit mactive, mdone;

  always #5 clk = ~clk;

  ship_placement_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_rotate(btn_rotate), .btn_place(btn_place), .num_ships(num_ships),
    .matrix(matrix), .cursor_x(cursor_x), .cursor_y(cursor_y), .orient(orient),
    .ship_idx(ship_idx), .busy(busy), .place_err(place_err), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int board_diff();
    int d = 0;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        if (matrix[y][x] !== mb[y][x]) d++;
    return d;
  endfunction

  function automatic logic [11:0] obs();
    return {cursor_x, cursor_y, orient, ship_idx, done, busy};
  endfunction

  function automatic logic [11:0] exp_obs();
    return {3'(mx), 3'(my), 1'(mo), 3'(midx), 1'(mdone), 1'b0};
  endfunction

  function automatic void model_reset();
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        mb[y][x] = 0;
    mx = 0; my = 0; mo = 0; midx = 0; mnum = 1;
    mactive = 0; mdone = 0;
  endfunction

  task automatic do_start(input int n, input string tag);
    num_ships = 3'(n);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        mb[y][x] = 0;
    mx = 0; my = 0; midx = 0;
    mnum = (n == 0) ? 1 : (n > 5 ? 5 : n);
    mactive = 1; mdone = 0;
    n_checks++;
    if (obs() !== exp_obs()) begin
      n_fail++;
      $display("FAIL %s start state: got %h expected %h", tag, obs(), exp_obs());
    end
    n_checks++;
    if (board_diff() !== 0) begin
      n_fail++;
      $display("FAIL %s start board: %0d cells differ, expected 0", tag, board_diff());
    end
  endtask

  // mask bits: 0 up, 1 down, 2 left, 3 right, 4 rotate, 5 place
  task automatic press(input logic [5:0] m, input string tag);
    int len, bad, cx, cy, lx, ly;
    {btn_place, btn_rotate, btn_right, btn_left, btn_down, btn_up} = m;
    tick;
    {btn_place, btn_rotate, btn_right, btn_left, btn_down, btn_up} = 6'b0;
    if (mactive && !mdone && m[5]) begin
      len = midx + 1;
      bad = -1;
      lx = 0; ly = 0;
      for (int i = 0; i < len; i++) begin
        cx = mx + (mo ? 0 : i);
        cy = my + (mo ? i : 0);
        lx = cx; ly = cy;
        if (bad < 0 && (cx > N - 1 || cy > N - 1 || mb[cy][cx] != 0)) bad = i;
      end
      if (bad >= 0) begin
        repeat (bad + 1) tick;
        n_checks++;
        if (place_err !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s reject pulse: place_err=%b busy=%b expected 1 0 (bad k=%0d)", tag, place_err, busy, bad);
        end
        tick;
        n_checks++;
        if (place_err !== 1'b0) begin
          n_fail++;
          $display("FAIL %s reject pulse width: place_err=%b expected 0", tag, place_err);
        end
      end else begin
        repeat (2 * len - 1) tick;
        n_checks++;
        if (busy !== 1'b1 || matrix[ly][lx] !== 0) begin
          n_fail++;
          $display("FAIL %s latency: busy=%b last cell=%0d expected 1 and 0 one cycle early", tag, busy, matrix[ly][lx]);
        end
        tick;
        for (int i = 0; i < len; i++) mb[my + (mo ? i : 0)][mx + (mo ? 0 : i)] = 6;
        midx++;
        if (midx == mnum) mdone = 1;
      end
    end else begin
      if (mactive && !mdone) begin
        if (m[4]) mo = 1 - mo;
        else begin
          if (m[0] && !m[1] && my > 0) my--;
          if (m[1] && !m[0] && my < N - 1) my++;
          if (m[2] && !m[3] && mx > 0) mx--;
          if (m[3] && !m[2] && mx < N - 1) mx++;
        end
      end
      tick;
      n_checks++;
      if (place_err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s spurious place_err: got %b expected 0", tag, place_err);
      end
    end
    n_checks++;
    if (obs() !== exp_obs()) begin
      n_fail++;
      $display("FAIL %s state {x,y,o,idx,done,busy}: got %h expected %h", tag, obs(), exp_obs());
    end
    n_checks++;
    if (board_diff() !== 0) begin
      n_fail++;
      $display("FAIL %s board: %0d cells differ, expected 0", tag, board_diff());
    end
  endtask

  task automatic test_reset;
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    n_checks++;
    if (obs() !== exp_obs() || place_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset state: got %h err=%b expected %h err=0", obs(), place_err, exp_obs());
    end
    n_checks++;
    if (board_diff() !== 0) begin
      n_fail++;
      $display("FAIL reset board: %0d cells nonzero, expected 0", board_diff());
    end
    press(6'b001000, "idle_drop");
  endtask

  task automatic test_spec_sequence;
    do_start(2, "seq");
    press(6'b100000, "seq_first_ship");
    n_checks++;
    if (matrix[0][0] !== 6 || ship_idx !== 3'd1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_first_cell: m00=%0d idx=%0d done=%b expected 6 1 0", matrix[0][0], ship_idx, done);
    end
    repeat (4) press(6'b001000, "seq_right");
    press(6'b100000, "seq_oob");
    repeat (4) press(6'b000100, "seq_left");
    if (mo == 0) press(6'b010000, "seq_rot_v");
    press(6'b100000, "seq_overlap");
    press(6'b010000, "seq_rot_h");
    repeat (2) press(6'b000010, "seq_down");
    repeat (3) press(6'b001000, "seq_right2");
    press(6'b100000, "seq_second_ship");
    n_checks++;
    if (matrix[2][3] !== 6 || matrix[2][4] !== 6 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_done: m23=%0d m24=%0d done=%b expected 6 6 1", matrix[2][3], matrix[2][4], done);
    end
    press(6'b000101, "seq_done_move");
    press(6'b110000, "seq_done_place");
  endtask

  task automatic test_saturation;
    do_start(3, "sat");
    press(6'b000100, "sat_left_edge");
    press(6'b000001, "sat_up_edge");
    press(6'b000011, "sat_up_down");
    press(6'b001010, "sat_down_right");
    press(6'b001100, "sat_left_right");
    repeat (6) press(6'b001010, "sat_far_corner");
    press(6'b110000, "sat_place_beats_rotate");
  endtask

  task automatic test_clamp;
    do_start(0, "clamp0");
    press(6'b100000, "clamp0_place");
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp0_done: got %b expected 1", done);
    end
  endtask

  task automatic test_reset_mid_write;
    do_start(2, "rmw");
    press(6'b100000, "rmw_first");
    press(6'b001000, "rmw_right");
    btn_place = 1'b1;
    tick;
    btn_place = 1'b0;
    repeat (3) tick;
    n_checks++;
    if (matrix[0][1] !== 6 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_partial: m01=%0d busy=%b expected 6 1", matrix[0][1], busy);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (board_diff() !== 0 || busy !== 1'b0 || ship_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL rmw_async_clear: %0d cells set busy=%b idx=%0d expected 0 0 0", board_diff(), busy, ship_idx);
    end
    tick;
    rst_n = 1'b1;
    tick;
    press(6'b001000, "rmw_idle_drop");
  endtask

  task automatic test_random;
    logic [5:0] m;
    int r;
    for (int round = 0; round < 6; round++) begin
      do_start($urandom_range(0, 7), "rnd");
      for (int a = 0; a < 120 && !mdone; a++) begin
        r = $urandom_range(0, 9);
        if (r < 3)       m = {1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
        else if (r == 3) m = 6'b010000;
        else             m = {2'b00, 4'($urandom_range(1, 15))};
        press(m, "rnd");
      end
    end
  endtask

  initial begin
    test_reset;
    test_spec_sequence;
    test_saturation;
    test_clamp;
    test_reset_mid_write;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
